// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule types and constants.
// Used by the round-key sequencer, its register file and the generator interface.
package aes_pkg;

  localparam int unsigned AES_NR   = 10;
  localparam int unsigned RK_DEPTH = 11;

  typedef logic [127:0] key128_t;
  typedef logic [3:0]   rk_idx_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam rk_idx_t RK_LAST    = rk_idx_t'(RK_DEPTH - 1);
  localparam rk_idx_t LAST_ROUND = rk_idx_t'(AES_NR - 1);

endpackage

// File: rtl/key_schedule_ctrl_if.sv
// Link between the key-schedule sequencer and the external round-key generator.
// master = sequencer side, slave = generator side.
interface key_schedule_ctrl_if;

  logic [3:0]       gk_round;
  aes_pkg::key128_t gk_inp_key;
  aes_pkg::key128_t gk_out_key;

  modport master (
    output gk_round,
    output gk_inp_key,
    input  gk_out_key
  );

  modport slave (
    input  gk_round,
    input  gk_inp_key,
    output gk_out_key
  );

endinterface

// File: rtl/rk_regfile.sv
// 11 x 128-bit round-key store: one synchronous write port, one combinational
// read port returning zero for indices beyond the last round key.
module rk_regfile
  import aes_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    we,
  input  rk_idx_t waddr,
  input  key128_t wdata,
  input  rk_idx_t raddr,
  output key128_t rdata
);

  key128_t mem [RK_DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < RK_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we && (waddr <= RK_LAST)) begin
      mem[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata = '0;
    if (raddr <= RK_LAST) begin
      rdata = mem[raddr];
    end
  end

endmodule

// File: rtl/key_schedule_ctrl.sv
// AES-128 round-key sequencer: steps an external generator through rounds 0..9,
// waiting SBOX_LAT cycles per round, and stores all 11 round keys.
module key_schedule_ctrl
  import aes_pkg::*;
#(
  parameter int unsigned SBOX_LAT = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  key128_t                    cipher_key,
  output logic                       busy,
  output logic                       done,
  output logic                       keys_valid,
  key_schedule_ctrl_if.master        gk,
  input  rk_idx_t                    rk_addr,
  output key128_t                    rk_data
);

  localparam logic [1:0] LAT_MAX = 2'(SBOX_LAT);

  state_t     state;
  state_t     state_nxt;
  key128_t    cur_key;
  rk_idx_t    round;
  logic [1:0] lat_cnt;
  logic       kv_q;

  logic       capture;
  logic       last_round;
  logic       rf_we;
  rk_idx_t    rf_waddr;
  key128_t    rf_wdata;

  assign capture    = (state == RUN) && (lat_cnt == LAT_MAX);
  assign last_round = (round == LAST_ROUND);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (capture && last_round) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The cipher key itself is round key 0, written on the accepting edge.
  always_comb begin
    busy     = 1'b0;
    done     = 1'b0;
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = gk.gk_out_key;
    unique case (state)
      IDLE: begin
        if (start) begin
          rf_we    = 1'b1;
          rf_wdata = cipher_key;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (capture) begin
          rf_we    = 1'b1;
          rf_waddr = round + 4'd1;
        end
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  // keys_valid is set on the final capture so it is already high alongside done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_key <= '0;
      round   <= '0;
      lat_cnt <= '0;
      kv_q    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            cur_key <= cipher_key;
            round   <= '0;
            lat_cnt <= '0;
            kv_q    <= 1'b0;
          end
        end
        RUN: begin
          if (capture) begin
            cur_key <= gk.gk_out_key;
            lat_cnt <= '0;
            if (last_round) begin
              kv_q <= 1'b1;
            end else begin
              round <= round + 4'd1;
            end
          end else begin
            lat_cnt <= lat_cnt + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign keys_valid    = kv_q;
  assign gk.gk_round   = round;
  assign gk.gk_inp_key = cur_key;

  rk_regfile u_rk_regfile (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (rf_we),
    .waddr (rf_waddr),
    .wdata (rf_wdata),
    .raddr (rk_addr),
    .rdata (rk_data)
  );

endmodule

// File: tb/tb_key_schedule_ctrl.sv
// Scoreboard bench for key_schedule_ctrl at SBOX_LAT=1 and SBOX_LAT=2, each lane
// with its own generator model and a FIPS-197 style key-expansion reference.
module tb_key_schedule_ctrl;
  import aes_pkg::*;

  typedef logic [10:0][127:0] keyset_t;
  typedef struct packed {
    keyset_t keys;
    int      c0;
    int      lat;
  } exp_t;

  logic clk = 1'b0;
  always #20 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  logic [7:0] sb_tab [256];

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = '0;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // S-box from its definition: multiplicative inverse (x^254) then the affine map.
  function automatic logic [7:0] sbox_calc(input logic [7:0] x);
    logic [7:0] inv = 8'h01;
    for (int i = 0; i < 254; i++) inv = gmul(inv, x);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  initial for (int i = 0; i < 256; i++) sb_tab[i] = sbox_calc(8'(i));

  function automatic logic [7:0] rcon(input int r);
    logic [7:0] v = 8'h01;
    for (int i = 0; i < r; i++) v = xt(v);
    return v;
  endfunction

  function automatic logic [31:0] sub_rot(input logic [31:0] w);
    return {sb_tab[w[23:16]], sb_tab[w[15:8]], sb_tab[w[7:0]], sb_tab[w[31:24]]};
  endfunction

  // Whole-key expansion over the 44-word schedule.
  function automatic keyset_t expand(input key128_t key);
    logic [31:0] w [44];
    logic [31:0] t;
    keyset_t ks;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) t = sub_rot(t) ^ {rcon(i/4 - 1), 24'h0};
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) ks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return ks;
  endfunction

  // One generator step: previous round key and round index to next round key.
  function automatic key128_t gen_next(input key128_t k, input logic [3:0] rnd);
    logic [31:0] n0, n1, n2, n3;
    n0 = k[127:96] ^ sub_rot(k[31:0]) ^ {rcon(int'(rnd)), 24'h0};
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = k[31:0]  ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  function automatic key128_t rand_key();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic void chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endfunction

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int LAT     = g + 1;
    localparam int LATENCY = 10 * (LAT + 1) + 1;

    logic    rst_n;
    logic    start;
    key128_t cipher_key;
    logic    busy;
    logic    done;
    logic    keys_valid;
    rk_idx_t rk_addr = '0;
    key128_t rk_data;

    exp_t sb_q [$];
    int   rst_pend = 0;
    int   rst_seen = 0;
    bit   exp_kv   = 1'b0;
    bit   finished = 1'b0;

    key_schedule_ctrl_if gk_bus ();

    key_schedule_ctrl #(.SBOX_LAT(LAT)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .cipher_key (cipher_key),
      .busy       (busy),
      .done       (done),
      .keys_valid (keys_valid),
      .gk         (gk_bus),
      .rk_addr    (rk_addr),
      .rk_data    (rk_data)
    );

    key128_t pipe [LAT];
    always @(posedge clk) begin
      pipe[0] <= gen_next(gk_bus.gk_inp_key, gk_bus.gk_round);
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign gk_bus.gk_out_key = pipe[LAT-1];

    function automatic string nm(input string s);
      return $sformatf("lane%0d_%s", g, s);
    endfunction

    always @(negedge clk) begin : monitor
      exp_t e;
      if (rst_pend != rst_seen) begin
        rst_seen = rst_pend;
        exp_kv   = 1'b0;
        chk(nm("rst_busy"), 128'(busy), '0);
        chk(nm("rst_done"), 128'(done), '0);
        chk(nm("rst_keys_valid"), 128'(keys_valid), '0);
        chk(nm("rst_gk_round"), 128'(gk_bus.gk_round), '0);
        chk(nm("rst_gk_inp_key"), gk_bus.gk_inp_key, '0);
        for (int a = 0; a < 16; a++) begin
          rk_addr = 4'(a);
          #1;
          chk(nm($sformatf("rst_rk%0d", a)), rk_data, '0);
        end
      end else if (sb_q.size() != 0) begin
        e = sb_q[0];
        if (done) begin
          void'(sb_q.pop_front());
          exp_kv = 1'b1;
          chk(nm("done_latency"), 128'(cyc - e.c0 + 1), 128'(e.lat));
          chk(nm("done_busy"), 128'(busy), 128'(1));
          chk(nm("done_keys_valid"), 128'(keys_valid), 128'(1));
          for (int a = 0; a < 16; a++) begin
            rk_addr = 4'(a);
            #1;
            if (a < 11) chk(nm($sformatf("rk%0d", a)), rk_data, e.keys[a]);
            else        chk(nm($sformatf("rk%0d_oob", a)), rk_data, '0);
          end
        end else if (cyc - e.c0 + 1 >= e.lat) begin
          void'(sb_q.pop_front());
          chk(nm("done_late"), 128'(done), 128'(1));
        end else if (cyc >= e.c0) begin
          chk(nm("run_busy"), 128'(busy), 128'(1));
          chk(nm("run_keys_valid"), 128'(keys_valid), '0);
        end
      end else if (rst_n) begin
        chk(nm("idle_done"), 128'(done), '0);
        chk(nm("idle_busy"), 128'(busy), '0);
        chk(nm("idle_keys_valid"), 128'(keys_valid), 128'(exp_kv));
      end
    end

    task automatic launch(input key128_t key, input keyset_t ks, input bit poke);
      exp_t e;
      @(negedge clk);
      start      = 1'b1;
      cipher_key = key;
      @(posedge clk);
      e.keys = ks;
      e.c0   = cyc + 1;
      e.lat  = LATENCY;
      sb_q.push_back(e);
      @(negedge clk);
      start      = 1'b0;
      cipher_key = rand_key();
      if (poke) begin
        repeat (4) @(negedge clk);
        start      = 1'b1;
        cipher_key = rand_key();
        @(negedge clk);
        start = 1'b0;
      end
    endtask

    task automatic wait_done();
      for (int n = 0; n < LATENCY + 20; n++) begin
        @(negedge clk);
        #2;
        cipher_key = rand_key();
        if (sb_q.size() == 0) break;
      end
      chk(nm("run_pending"), 128'(sb_q.size()), '0);
      sb_q.delete();
    endtask

    task automatic reset_mid_run(input key128_t key);
      launch(key, expand(key), 1'b0);
      repeat (8) @(negedge clk);
      #2;
      rst_n = 1'b0;
      sb_q.delete();
      rst_pend++;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
    endtask

    initial begin : stim
      key128_t fips;
      key128_t k;
      keyset_t ks;
      fips       = 128'h2b7e151628aed2a6abf7158809cf4f3c;
      rst_n      = 1'b0;
      start      = 1'b0;
      cipher_key = '0;
      rst_pend   = 1;
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b1;

      ks     = expand(fips);
      ks[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
      ks[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
      launch(fips, ks, 1'b0);
      wait_done();

      ks     = expand('0);
      ks[10] = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
      launch('0, ks, 1'b0);
      wait_done();

      ks     = expand(fips);
      ks[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
      ks[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
      launch(fips, ks, 1'b1);
      wait_done();

      reset_mid_run(rand_key());

      for (int n = 0; n < 3; n++) begin
        k = rand_key();
        launch(k, expand(k), n == 1);
        wait_done();
      end
      finished = 1'b1;
    end
  end

  initial begin : summary
    for (int n = 0; n < 4000; n++) begin
      @(posedge clk);
      if (lane[0].finished && lane[1].finished) break;
    end
    if (!(lane[0].finished && lane[1].finished)) begin
      checks++;
      failures++;
      $display("FAIL tb_timeout finished=%0d%0d required=11", lane[0].finished, lane[1].finished);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/key_schedule_ctrl.md
# key_schedule_ctrl

Sequencer for the AES-128 round-key generator. On `start`, it captures a 128-bit cipher key and drives the generator through rounds 0..9. It waits out the generator's registered S-box latency each round and stores all 11 round keys in an internal register file. The cipher datapath reads the file through a combinational port. The block sits between the AXI/BRAM-facing control logic and the encrypt/decrypt round pipeline.

## Interface

**Parameters**
- `SBOX_LAT`, default 1: clock cycles from a change on `gk_inp_key` to a valid `gk_out_key`. Legal range is 1..3.

**Ports**
- `clk`, input, 1: system clock. Rising edge.
- `rst_n`, input, 1: reset. Asynchronous, active-low.
- `start`, input, 1: begin expansion. Sampled only in IDLE.
- `cipher_key`, input, 128: key. Sampled on the cycle `start` is accepted.
- `busy`, output, 1: high while in RUN or DONE.
- `done`, output, 1: one-cycle pulse when all 11 keys are stored.
- `keys_valid`, output, 1: high from `done` until the next accepted `start`.
- `gk_round`, output, 4: round index to the generator.
- `gk_inp_key`, output, 128: previous round key to the generator.
- `gk_out_key`, input, 128: next round key from the generator.
- `rk_addr`, input, 4: round-key read index, 0..10.
- `rk_data`, output, 128: round key at `rk_addr`. Combinational.

## Operation

**States**
- IDLE: waiting for `start`.
- RUN: stepping the generator through rounds 0..9.
- DONE: one-cycle completion state.

**Internal registers**
- `cur_key` (128 bits): drives `gk_inp_key`.
- `round` (4 bits): drives `gk_round`.
- `lat_cnt` (2 bits).
- `rk[0..10]`: 128 bits each.

**IDLE**
- `start`=1 → on the clock edge:
  - `rk[0]` and `cur_key` load `cipher_key`.
  - `round` and `lat_cnt` clear to 0.
  - `keys_valid` clears.
  - State goes to RUN.
- `start`=0 → stay in IDLE.

**RUN**
- `lat_cnt` < `SBOX_LAT` → `lat_cnt` increments.
- `lat_cnt` == `SBOX_LAT` → capture:
  - `rk[round+1]` and `cur_key` load `gk_out_key`.
  - `lat_cnt` clears to 0.
  - If `round` == 9, state goes to DONE. Otherwise `round` increments.

**DONE**
- `done`=1 and `keys_valid` sets.
- Next edge → IDLE, with `done`=0 and `keys_valid` held at 1.

**Boundary conditions**
- `start` while in RUN or DONE is ignored. It has no effect on the keys.
- `cipher_key` changes after acceptance have no effect.
- `rk_addr` 11..15 → `rk_data` = 0.
- `rk` entries are rewritten progressively during a new run. Readers gate on `keys_valid`.
- `rst_n` low at any time, including mid-RUN:
  - State goes to IDLE.
  - All `rk` entries, `cur_key`, `round` and `lat_cnt` clear to 0.
  - `done`, `busy` and `keys_valid` go to 0.
  - There is no partial-key retention.

## Timing

- **Reset values:** all outputs are 0 (`gk_inp_key`=0, `gk_round`=0, `rk_data`=0 for any address).
- **Edge numbering:** E0 is the edge that accepts `start`.
- **Capture edges:** round r is captured at edge E((r+1)·(SBOX_LAT+1)).
  - With `SBOX_LAT`=1, captures land at E2, E4, … E20.
  - `done` is high in the cycle after E20.
- **Latency:** `start`-to-`done` is 10·(SBOX_LAT+1)+1 cycles, which is 21 at the default.
- **Generator inputs:** `gk_inp_key` and `gk_round` are registered. They are stable for the whole SBOX_LAT+1 window of each round.
- **`busy`:** rises the cycle after E0 and falls with `done`.
- **Back-to-back runs:** the earliest next `start` is accepted in the first IDLE cycle after `done`.

## Structure

**Shared package `aes_pkg`**
- `AES_NR` = 10
- `RK_DEPTH` = 11
- `state_t` enumeration (IDLE, RUN, DONE)
- `key128_t` typedef

**Sub-module**
- `rk_regfile`: 11×128-bit register file with one synchronous write port, one combinational read port, zero-fill for out-of-range reads, and asynchronous clear.
- The FSM and counters live in `key_schedule_ctrl`.
- The round-key generator is instantiated beside this block in the parent and wired through the `gk_*` ports.

## Test plan

1. FIPS-197 key `2b7e151628aed2a6abf7158809cf4f3c`, `start` pulse, expected results:
   - `done` at cycle 21.
   - `rk[1]` = `a0fafe1788542cb123a339392a6c7605`.
   - `rk[10]` = `d014f9a8c9ee2589e13f0cc8b6630ca6`.
2. All-zero key → `rk[10]` = `b4ef5bcb3e92e21123e951cf6f8f188e`; `keys_valid`=1 after `done`.
3. Pulse `start` during RUN with a different key → keys identical to scenario 1; `done` still at cycle 21.
4. Drop `rst_n` at cycle 9 of a run, then release it:
   - All outputs read 0 and the block is in IDLE.
   - A new `start` completes normally.
5. Read `rk_addr` 11 and 15 → `rk_data`=0. Drive `SBOX_LAT`=2 with a matching generator model → `done` at cycle 31 with the same keys as scenario 1.
